// File: rtl/cpu_pkg.sv
// Shared CPU datapath encodings: ALU control codes, ALUOp classes and R-type funct values.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decoder producing the 4-bit ALU control code and an illegal flag.
module alu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_control_o,
    output logic       illegal_o
);

    // Unsupported encodings still produce ADD so the ALU sees a harmless operation.
    always_comb begin
        alu_control_o = ALU_ADD;
        illegal_o     = 1'b0;
        case (alu_op_e'(alu_op_i))
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: alu_control_o = ALU_ADD;
                    FUNCT_SUB: alu_control_o = ALU_SUB;
                    FUNCT_AND: alu_control_o = ALU_AND;
                    FUNCT_OR:  alu_control_o = ALU_OR;
                    FUNCT_SLT: alu_control_o = ALU_SLT;
                    FUNCT_NOR: alu_control_o = ALU_NOR;
                    default: begin
                        alu_control_o = ALU_ADD;
                        illegal_o     = 1'b1;
                    end
                endcase
            end
            default: begin
                alu_control_o = ALU_ADD;
                illegal_o     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and load-use detection.
// Optional macro EX_OPERAND_FWD_EN enables EX/MEM and MEM/WB forwarding; without it hazards stall.
module ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
)
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_to_reg,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          flush,
    input  logic          ex_hold,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          mwb_reg_write,
    input  logic [RW-1:0] mwb_rd,
    input  logic [DW-1:0] mwb_data,
    output logic          hazard_stall,
    output logic [DW-1:0] alu_data1,
    output logic [DW-1:0] alu_data2,
    output logic [3:0]    alu_control,
    output logic [DW-1:0] ex_rt_fwd,
    output logic [RW-1:0] ex_write_reg,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_to_reg,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_illegal
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] write_reg;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic          alu_src;
        logic          reg_write;
        logic          mem_to_reg;
        logic          mem_read;
        logic          mem_write;
        logic [3:0]    alu_control;
        logic          illegal;
    } ex_reg_t;

    localparam ex_reg_t EX_BUBBLE = '{alu_control: ALU_ADD, default: '0};

    ex_reg_t      exStage_q;
    ex_reg_t      exStage_d;
    ex_reg_t      capture;
    logic [3:0]   decCtrl;
    logic         decIllegal;
    logic         idReadsRt;
    logic         matchEx;
    logic         loadUse;
    logic [DW-1:0] rsFwd;
    logic [DW-1:0] rtFwd;

    alu_ctrl_decode u_decode (
        .alu_op_i      (id_alu_op),
        .funct_i       (id_funct),
        .alu_control_o (decCtrl),
        .illegal_o     (decIllegal)
    );

    // Controls are qualified by id_valid so an empty ID slot never carries side effects.
    always_comb begin
        capture             = EX_BUBBLE;
        capture.valid       = id_valid;
        capture.rs          = id_rs;
        capture.rt          = id_rt;
        capture.write_reg   = id_reg_dst ? id_rd : id_rt;
        capture.rs_data     = id_rs_data;
        capture.rt_data     = id_rt_data;
        capture.imm         = id_imm;
        capture.alu_src     = id_alu_src;
        capture.reg_write   = id_valid & id_reg_write;
        capture.mem_to_reg  = id_valid & id_mem_to_reg;
        capture.mem_read    = id_valid & id_mem_read;
        capture.mem_write   = id_valid & id_mem_write;
        capture.alu_control = decCtrl;
        capture.illegal     = decIllegal;
    end

    always_comb begin
        exStage_d = exStage_q;
        if (flush) begin
            exStage_d = EX_BUBBLE;
        end else if (ex_hold) begin
            exStage_d = exStage_q;
        end else if (hazard_stall) begin
            exStage_d = EX_BUBBLE;
        end else begin
            exStage_d = capture;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exStage_q <= EX_BUBBLE;
        end else begin
            exStage_q <= exStage_d;
        end
    end

    // rt only counts as a source when the ID instruction actually reads it (R-type or store).
    assign idReadsRt = ~id_alu_src | id_mem_write;
    assign matchEx   = (exStage_q.write_reg != '0) &&
                       ((exStage_q.write_reg == id_rs) ||
                        (idReadsRt && (exStage_q.write_reg == id_rt)));
    assign loadUse   = id_valid & exStage_q.valid & exStage_q.mem_read & matchEx;

`ifdef EX_OPERAND_FWD_EN
    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    function automatic logic [DW-1:0] fwdSel(input logic [RW-1:0] idx,
                                             input logic [DW-1:0] regVal,
                                             input logic          exmWe,
                                             input logic [RW-1:0] exmIdx,
                                             input logic [DW-1:0] exmVal,
                                             input logic          mwbWe,
                                             input logic [RW-1:0] mwbIdx,
                                             input logic [DW-1:0] mwbVal);
        if (exmWe && (exmIdx != '0) && (exmIdx == idx)) begin
            return exmVal;
        end else if (mwbWe && (mwbIdx != '0) && (mwbIdx == idx)) begin
            return mwbVal;
        end
        return regVal;
    endfunction

    assign rsFwd = fwdSel(exStage_q.rs, exStage_q.rs_data, exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_data);
    assign rtFwd = fwdSel(exStage_q.rt, exStage_q.rt_data, exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_data);
    assign hazard_stall = loadUse;
`else
    logic matchExm;
    logic dataHazard;
    logic unused_fwd;

    // Without bypass paths any in-flight producer in EX or EX/MEM must drain first;
    // the register file writes before it reads, so MEM/WB is already visible.
    assign matchExm   = (exm_rd != '0) &&
                        ((exm_rd == id_rs) || (idReadsRt && (exm_rd == id_rt)));
    assign dataHazard = id_valid & ((exStage_q.valid & exStage_q.reg_write & matchEx) |
                                    (exm_reg_write & matchExm));
    assign rsFwd        = exStage_q.rs_data;
    assign rtFwd        = exStage_q.rt_data;
    assign hazard_stall = loadUse | dataHazard;
    assign unused_fwd   = ^{exm_result, mwb_reg_write, mwb_rd, mwb_data, exStage_q.rs, exStage_q.rt};
`endif

    assign alu_data1     = rsFwd;
    assign alu_data2     = exStage_q.alu_src ? exStage_q.imm : rtFwd;
    assign ex_rt_fwd     = rtFwd;
    assign alu_control   = exStage_q.alu_control;
    assign ex_write_reg  = exStage_q.write_reg;
    assign ex_valid      = exStage_q.valid;
    assign ex_reg_write  = exStage_q.reg_write;
    assign ex_mem_to_reg = exStage_q.mem_to_reg;
    assign ex_mem_read   = exStage_q.mem_read;
    assign ex_mem_write  = exStage_q.mem_write;
    assign ex_illegal    = exStage_q.valid & exStage_q.illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: instruction-level reference model plus directed vectors.
// Works for both settings of EX_OPERAND_FWD_EN.
module tb_ex_operand_stage;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef EX_OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          id_valid, id_alu_src, id_reg_dst, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [1:0]    id_alu_op;
    logic [5:0]    id_funct;
    logic          flush, ex_hold, exm_reg_write, mwb_reg_write;
    logic [RW-1:0] exm_rd, mwb_rd;
    logic [DW-1:0] exm_result, mwb_data;
    logic          hazard_stall;
    logic [DW-1:0] alu_data1, alu_data2, ex_rt_fwd;
    logic [3:0]    alu_control;
    logic [RW-1:0] ex_write_reg;
    logic          ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_illegal;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    always #5 clk = ~clk;

    ex_operand_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_hold(ex_hold),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .hazard_stall(hazard_stall), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_control(alu_control), .ex_rt_fwd(ex_rt_fwd), .ex_write_reg(ex_write_reg),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
    );

    // Reference: the instruction currently sitting in EX, as a plain record.
    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs, rt, wr;
        logic [DW-1:0] rsd, rtd, imm;
        logic          src, rw, m2r, mr, mw;
        logic [3:0]    ctl;
        logic          ill;
    } mdl_t;

    localparam mdl_t MDL_BUBBLE = '{ctl: 4'b0010, default: '0};
    mdl_t m;

    function automatic logic [4:0] refDecode(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 5'b0_0010;
        if (op == 2'b01) return 5'b0_0110;
        if (op == 2'b11) return 5'b1_0010;
        case (fn)
            6'b100000: return 5'b0_0010;
            6'b100010: return 5'b0_0110;
            6'b100100: return 5'b0_0000;
            6'b100101: return 5'b0_0001;
            6'b101010: return 5'b0_0111;
            6'b100111: return 5'b0_1100;
            default:   return 5'b1_0010;
        endcase
    endfunction

    function automatic logic [DW-1:0] refFwd(input logic [RW-1:0] idx, input logic [DW-1:0] regVal);
        if (FWD && exm_reg_write && exm_rd != 0 && exm_rd == idx) return exm_result;
        if (FWD && mwb_reg_write && mwb_rd != 0 && mwb_rd == idx) return mwb_data;
        return regVal;
    endfunction

    function automatic logic readsReg(input logic [RW-1:0] r);
        logic usesRt;
        usesRt = !id_alu_src || id_mem_write;
        return (r != 0) && (r == id_rs || (usesRt && r == id_rt));
    endfunction

    function automatic logic refHazard();
        logic h;
        h = id_valid && m.valid && m.mr && readsReg(m.wr);
        if (!FWD && id_valid && ((m.valid && m.rw && readsReg(m.wr)) || (exm_reg_write && readsReg(exm_rd))))
            h = 1'b1;
        return h;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= MDL_BUBBLE;
        end else begin : upd
            mdl_t n;
            n = MDL_BUBBLE;
            if (flush) begin
                n = MDL_BUBBLE;
            end else if (ex_hold) begin
                n = m;
            end else if (refHazard()) begin
                n = MDL_BUBBLE;
            end else begin
                n.valid = id_valid;
                n.rs = id_rs; n.rt = id_rt;
                n.wr = id_reg_dst ? id_rd : id_rt;
                n.rsd = id_rs_data; n.rtd = id_rt_data; n.imm = id_imm;
                n.src = id_alu_src;
                n.rw = id_valid && id_reg_write;
                n.m2r = id_valid && id_mem_to_reg;
                n.mr = id_valid && id_mem_read;
                n.mw = id_valid && id_mem_write;
                {n.ill, n.ctl} = refDecode(id_alu_op, id_funct);
            end
            m <= n;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, the whole output set must match what the model's EX instruction implies.
    always @(negedge clk) begin
        if (cmpEn) begin
            logic [DW-1:0] rtExp;
            rtExp = refFwd(m.rt, m.rtd);
            checkOutput("cyc_valid", ex_valid, m.valid);
            checkOutput("cyc_ctl", alu_control, m.ctl);
            checkOutput("cyc_ill", ex_illegal, m.valid && m.ill);
            checkOutput("cyc_d1", alu_data1, refFwd(m.rs, m.rsd));
            checkOutput("cyc_d2", alu_data2, m.src ? m.imm : rtExp);
            checkOutput("cyc_rtfwd", ex_rt_fwd, rtExp);
            checkOutput("cyc_wr", ex_write_reg, m.wr);
            checkOutput("cyc_ctrls", {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write},
                        {m.rw, m.m2r, m.mr, m.mw});
            checkOutput("cyc_haz", hazard_stall, refHazard());
        end
    end

    task automatic applyStimulus(input logic v, input logic [RW-1:0] rs, rt, rd,
                                 input logic [1:0] op, input logic [5:0] fn,
                                 input logic src, dst, rw, m2r, mr, mw,
                                 input logic [DW-1:0] rsd, rtd, imm);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_alu_op = op; id_funct = fn;
        id_alu_src = src; id_reg_dst = dst; id_reg_write = rw;
        id_mem_to_reg = m2r; id_mem_read = mr; id_mem_write = mw;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 2'b00, 6'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [1:0] decOp  [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [5:0] decFn  [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h24, 6'h24, 6'h20};
    logic [3:0] decCtl [10] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'hC, 4'h2, 4'h2, 4'h6, 4'h2};
    logic       decIll [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1};

    initial begin
        idle();
        flush = 0; ex_hold = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
        #12 reset_n = 1'b1;
        step();
        cmpEn = 1'b1;
        checkOutput("rst_valid", ex_valid, 0);
        checkOutput("rst_ctl", alu_control, 4'b0010);
        checkOutput("rst_haz", hazard_stall, 0);
        checkOutput("rst_d1", alu_data1, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 2, 5, decOp[i], decFn[i], 0, 1, 1, 0, 0, 0, 32'h100 + i, 32'h200 + i, 0);
            step();
            checkOutput("dec_ctl", alu_control, decCtl[i]);
            checkOutput("dec_ill", ex_illegal, decIll[i]);
            checkOutput("model_ctl", m.ctl, decCtl[i]);
            checkOutput("dec_d1", alu_data1, 32'h100 + i);
        end
        idle(); step();

        // Producer in EX/MEM overrides stale register data; EX/MEM beats MEM/WB.
        applyStimulus(1, 3, 6, 8, 2'b10, 6'h20, 0, 1, 1, 0, 0, 0, 32'h9, 32'h11, 32'h44);
        step();
        idle(); ex_hold = 1;
        exm_reg_write = 1; exm_rd = 3; exm_result = 32'h5;
        step();
        checkOutput("fwd_exm", alu_data1, FWD ? 32'h5 : 32'h9);
        mwb_reg_write = 1; mwb_rd = 3; mwb_data = 32'h7;
        step();
        checkOutput("fwd_both", alu_data1, FWD ? 32'h5 : 32'h9);
        exm_reg_write = 0; mwb_rd = 6;
        step();
        checkOutput("fwd_mwb_rt", alu_data2, FWD ? 32'h7 : 32'h11);
        checkOutput("fwd_hold_d1", alu_data1, 32'h9);
        mwb_reg_write = 0; ex_hold = 0;
        step();

        // Register 0 is never bypassed.
        applyStimulus(1, 0, 0, 8, 2'b00, 6'h0, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h10);
        step();
        idle(); ex_hold = 1;
        exm_reg_write = 1; exm_rd = 0; exm_result = 32'hDEAD;
        mwb_reg_write = 1; mwb_rd = 0; mwb_data = 32'hBEEF;
        step();
        checkOutput("zero_guard", alu_data1, 0);
        exm_reg_write = 0; mwb_reg_write = 0; ex_hold = 0;
        step();

        // Load-use: one bubble, then the consumer picks the load value from MEM/WB.
        applyStimulus(1, 1, 4, 0, 2'b00, 6'h0, 1, 0, 1, 1, 1, 0, 32'h1000, 0, 32'h8);
        step();
        checkOutput("lw_mr", ex_mem_read, 1);
        checkOutput("lw_d2", alu_data2, 32'h8);
        applyStimulus(1, 4, 2, 9, 2'b10, 6'h20, 0, 1, 1, 0, 0, 0, 32'h4444, 32'h22, 0);
        #1 checkOutput("lu_haz", hazard_stall, 1);
        step();
        checkOutput("lu_bubble", ex_valid, 0);
        mwb_reg_write = 1; mwb_rd = 4; mwb_data = 32'h77;
        #1 checkOutput("lu_haz_clear", hazard_stall, 0);
        step();
        checkOutput("lu_valid", ex_valid, 1);
        checkOutput("lu_fwd", alu_data1, FWD ? 32'h77 : 32'h4444);
        mwb_reg_write = 0; idle(); step();

        // rt only matters when the consumer reads it; flush beats the stall.
        applyStimulus(1, 1, 4, 0, 2'b00, 6'h0, 1, 0, 1, 1, 1, 0, 32'h1000, 0, 32'h8);
        step();
        applyStimulus(1, 1, 4, 0, 2'b00, 6'h0, 1, 0, 1, 0, 0, 0, 32'h1, 32'h2, 32'h3);
        #1 checkOutput("addi_rt_nohaz", hazard_stall, 0);
        applyStimulus(1, 1, 4, 0, 2'b00, 6'h0, 1, 0, 0, 0, 0, 1, 32'h1, 32'h2, 32'h3);
        #1 checkOutput("sw_rt_haz", hazard_stall, 1);
        ex_hold = 1;
        step();
        checkOutput("hold_haz_valid", ex_valid, 1);
        checkOutput("hold_haz_mr", ex_mem_read, 1);
        checkOutput("hold_haz", hazard_stall, 1);
        ex_hold = 0; flush = 1;
        #1 checkOutput("flush_haz", hazard_stall, 1);
        step();
        checkOutput("flush_bubble", ex_valid, 0);

        // Flush with hold still squashes; hold alone freezes for several cycles.
        applyStimulus(1, 7, 8, 10, 2'b10, 6'h22, 0, 1, 1, 0, 0, 0, 32'h70, 32'h80, 0);
        flush = 0;
        step();
        flush = 1; ex_hold = 1;
        step();
        checkOutput("flush_hold", ex_valid, 0);
        flush = 0; ex_hold = 0;
        step();
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 11, 12, 13, 2'b10, 6'h24, 0, 1, 1, 0, 0, 0, 32'h500 + i, 32'h600 + i, 0);
            step();
            checkOutput("hold_valid", ex_valid, 1);
            checkOutput("hold_d1", alu_data1, 32'h70);
            checkOutput("hold_ctl", alu_control, 4'b0110);
        end

        // Asynchronous reset while frozen clears the stage immediately.
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_hold_valid", ex_valid, 0);
        checkOutput("rst_hold_ctl", alu_control, 4'b0010);
        checkOutput("rst_hold_haz", hazard_stall, 0);
        #4 reset_n = 1'b1;
        ex_hold = 0; idle();
        step(); step();
        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
